// File: rtl/ctrl_pipe_hazard_if.sv
// Handshake and pipeline-observation bundle between the decoder and ctrl_pipe_hazard.
interface ctrl_pipe_hazard_if;
  logic [31:0] in_ctrl;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ex_ctrl;
  logic        ex_valid;
  logic [31:0] mem_ctrl;
  logic        mem_valid;
  logic [31:0] wb_ctrl;
  logic        wb_valid;
  logic [15:0] stall_count;

  modport master (
    output in_ctrl, in_valid,
    input  in_ready, ex_ctrl, ex_valid, mem_ctrl, mem_valid,
           wb_ctrl, wb_valid, stall_count
  );

  modport slave (
    input  in_ctrl, in_valid,
    output in_ready, ex_ctrl, ex_valid, mem_ctrl, mem_valid,
           wb_ctrl, wb_valid, stall_count
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Carries decoder control words through EX/MEM/WB, inserting bubbles on register
// RAW hazards and holding EX while a multi-cycle multiply completes.
module ctrl_pipe_hazard #(
  parameter int unsigned MUL_LAT   = 3,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_pipe_hazard_if.slave bus
);
  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  logic [31:0] r_ex_ctrl;
  logic [31:0] r_mem_ctrl;
  logic [31:0] r_wb_ctrl;
  logic        r_ex_valid;
  logic        r_mem_valid;
  logic        r_wb_valid;
  logic [3:0]  r_mul_cnt;
  logic [15:0] r_stall_cnt;

  logic [4:0]  w_src_rs;
  logic [4:0]  w_src_rt;
  logic        w_rt_used;
  logic        w_haz_ex;
  logic        w_haz_mem;
  logic        w_haz_wb;
  logic        w_hazard;
  logic        w_mul_busy;
  logic        w_in_ready;
  logic        w_accept;

  function automatic logic raw_hit(
    input logic       valid,
    input logic       wr_rf,
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic       rt_used,
    input logic [4:0] rt
  );
    return valid & wr_rf & (rd != 5'd0) & ((rd == rs) | (rt_used & (rd == rt)));
  endfunction

  assign w_src_rs  = bus.in_ctrl[21:17];
  assign w_src_rt  = bus.in_ctrl[16:12];
  // A load (extend=1 with a register-file write) names its destination in rt, so rt is not read.
  assign w_rt_used = ~bus.in_ctrl[23] | ~bus.in_ctrl[6];

  assign w_haz_ex  = raw_hit(r_ex_valid, r_ex_ctrl[6], r_ex_ctrl[11:7],
                             w_src_rs, w_rt_used, w_src_rt);
  assign w_haz_mem = raw_hit(r_mem_valid, r_mem_ctrl[6], r_mem_ctrl[11:7],
                             w_src_rs, w_rt_used, w_src_rt);
  assign w_haz_wb  = WB_BYPASS ? 1'b0 :
                     raw_hit(r_wb_valid, r_wb_ctrl[6], r_wb_ctrl[11:7],
                             w_src_rs, w_rt_used, w_src_rt);
  assign w_hazard  = w_haz_ex | w_haz_mem | w_haz_wb;

  assign w_mul_busy = r_ex_valid & r_ex_ctrl[22] & (r_mul_cnt != MUL_LAST);
  assign w_in_ready = ~w_mul_busy & ~(bus.in_valid & w_hazard);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Pipeline registers: hold EX during a multiply, otherwise advance and fill EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_ctrl   <= 32'd0;
      r_ex_valid  <= 1'b0;
      r_mem_ctrl  <= 32'd0;
      r_mem_valid <= 1'b0;
      r_wb_ctrl   <= 32'd0;
      r_wb_valid  <= 1'b0;
      r_mul_cnt   <= 4'd0;
    end else if (w_mul_busy) begin
      r_mul_cnt   <= r_mul_cnt + 4'd1;
      r_mem_ctrl  <= 32'd0;
      r_mem_valid <= 1'b0;
      r_wb_ctrl   <= r_mem_ctrl;
      r_wb_valid  <= r_mem_valid;
    end else begin
      r_mul_cnt   <= 4'd0;
      r_wb_ctrl   <= r_mem_ctrl;
      r_wb_valid  <= r_mem_valid;
      r_mem_ctrl  <= r_ex_ctrl;
      r_mem_valid <= r_ex_valid;
      if (w_accept) begin
        r_ex_ctrl  <= bus.in_ctrl;
        r_ex_valid <= 1'b1;
      end else begin
        r_ex_ctrl  <= 32'd0;
        r_ex_valid <= 1'b0;
      end
    end
  end

  // Saturating count of cycles where the decoder offered a word that was refused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (bus.in_valid && !w_in_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.ex_ctrl     = r_ex_ctrl;
  assign bus.ex_valid    = r_ex_valid;
  assign bus.mem_ctrl    = r_mem_ctrl;
  assign bus.mem_valid   = r_mem_valid;
  assign bus.wb_ctrl     = r_wb_ctrl;
  assign bus.wb_valid    = r_wb_valid;
  assign bus.stall_count = r_stall_cnt;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: instance 0 (MUL_LAT=3, WB bypass) and instance 1
// (MUL_LAT=15, no WB bypass) driven by tables, hand sequences and random words.
module tb_ctrl_pipe_hazard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  ctrl_pipe_hazard_if ifa ();
  ctrl_pipe_hazard_if ifb ();

  ctrl_pipe_hazard #(.MUL_LAT(3), .WB_BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  ctrl_pipe_hazard #(.MUL_LAT(15), .WB_BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  logic [31:0] drv_ctrl [2];
  logic        drv_valid [2];
  assign ifa.in_ctrl  = drv_ctrl[0];
  assign ifa.in_valid = drv_valid[0];
  assign ifb.in_ctrl  = drv_ctrl[1];
  assign ifb.in_valid = drv_valid[1];

  logic        obs_ready [2];
  logic [31:0] obs_ex [2];
  logic [31:0] obs_mem [2];
  logic [31:0] obs_wb [2];
  logic        obs_exv [2];
  logic        obs_memv [2];
  logic        obs_wbv [2];
  logic [15:0] obs_stall [2];
  assign obs_ready[0] = ifa.in_ready;    assign obs_ready[1] = ifb.in_ready;
  assign obs_ex[0]    = ifa.ex_ctrl;     assign obs_ex[1]    = ifb.ex_ctrl;
  assign obs_mem[0]   = ifa.mem_ctrl;    assign obs_mem[1]   = ifb.mem_ctrl;
  assign obs_wb[0]    = ifa.wb_ctrl;     assign obs_wb[1]    = ifb.wb_ctrl;
  assign obs_exv[0]   = ifa.ex_valid;    assign obs_exv[1]   = ifb.ex_valid;
  assign obs_memv[0]  = ifa.mem_valid;   assign obs_memv[1]  = ifb.mem_valid;
  assign obs_wbv[0]   = ifa.wb_valid;    assign obs_wbv[1]   = ifb.wb_valid;
  assign obs_stall[0] = ifa.stall_count; assign obs_stall[1] = ifb.stall_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stage contents plus "cycles left in EX" for each instance.
  logic [31:0] m_ex [2];
  logic [31:0] m_mem [2];
  logic [31:0] m_wb [2];
  logic        m_exv [2];
  logic        m_memv [2];
  logic        m_wbv [2];
  int          m_rem [2];
  int          m_stall [2];
  bit          m_acc [2];

  function automatic int ml(int i);
    return (i == 0) ? 3 : 15;
  endfunction

  function automatic bit byp(int i);
    return (i == 0);
  endfunction

  function automatic logic rst_of(int i);
    return (i == 0) ? rst_a : rst_b;
  endfunction

  function automatic logic [31:0] mkw(int rs, int rt, int rd, bit mul, bit ext, bit wrf);
    return {8'h00, ext, mul, 5'(rs), 5'(rt), 5'(rd), wrf, 6'h24};
  endfunction

  function automatic logic [31:0] srcs(logic [31:0] w);
    logic [31:0] m;
    m = 32'd0;
    m[w[21:17]] = 1'b1;
    if (!w[23] || !w[6]) m[w[16:12]] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] dst(logic v, logic [31:0] w);
    if (v && w[6] && (w[11:7] != 5'd0)) return 32'd1 << w[11:7];
    return 32'd0;
  endfunction

  function automatic bit model_ready(int i);
    bit          busy;
    logic [31:0] blk;
    busy = m_exv[i] && (m_rem[i] > 1);
    blk  = dst(m_exv[i], m_ex[i]) | dst(m_memv[i], m_mem[i]);
    if (!byp(i)) blk = blk | dst(m_wbv[i], m_wb[i]);
    return !busy && !(drv_valid[i] && ((srcs(drv_ctrl[i]) & blk) != 32'd0));
  endfunction

  task automatic model_reset(int i);
    m_ex[i] = 32'd0;  m_mem[i] = 32'd0;  m_wb[i] = 32'd0;
    m_exv[i] = 1'b0;  m_memv[i] = 1'b0;  m_wbv[i] = 1'b0;
    m_rem[i] = 0;     m_stall[i] = 0;    m_acc[i] = 1'b0;
  endtask

  task automatic model_step(int i, bit rdy);
    bit busy;
    busy = m_exv[i] && (m_rem[i] > 1);
    if (drv_valid[i] && !rdy && m_stall[i] < 65535) m_stall[i]++;
    m_acc[i] = drv_valid[i] && rdy;
    m_wb[i]  = m_mem[i];
    m_wbv[i] = m_memv[i];
    if (busy) begin
      m_rem[i]--;
      m_mem[i] = 32'd0;
      m_memv[i] = 1'b0;
    end else begin
      m_mem[i]  = m_ex[i];
      m_memv[i] = m_exv[i];
      if (m_acc[i]) begin
        m_ex[i]  = drv_ctrl[i];
        m_exv[i] = 1'b1;
        m_rem[i] = drv_ctrl[i][22] ? ml(i) : 1;
      end else begin
        m_ex[i]  = 32'd0;
        m_exv[i] = 1'b0;
        m_rem[i] = 0;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic advance();
    bit r [2];
    for (int i = 0; i < 2; i++) r[i] = model_ready(i);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst_of(i)) model_reset(i);
      else model_step(i, r[i]);
    end
    #1;
  endtask

  task automatic chk_ready(int i);
    chk($sformatf("ready%0d", i), 32'(obs_ready[i]), 32'(model_ready(i)));
  endtask

  task automatic chk_outs(int i);
    chk($sformatf("ex_ctrl%0d", i), obs_ex[i], m_ex[i]);
    chk($sformatf("ex_valid%0d", i), 32'(obs_exv[i]), 32'(m_exv[i]));
    chk($sformatf("mem_ctrl%0d", i), obs_mem[i], m_mem[i]);
    chk($sformatf("mem_valid%0d", i), 32'(obs_memv[i]), 32'(m_memv[i]));
    chk($sformatf("wb_ctrl%0d", i), obs_wb[i], m_wb[i]);
    chk($sformatf("wb_valid%0d", i), 32'(obs_wbv[i]), 32'(m_wbv[i]));
    chk($sformatf("stall%0d", i), 32'(obs_stall[i]), 32'(m_stall[i]));
  endtask

  function automatic logic [31:0] rand_word();
    return {8'h00, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
            5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63))};
  endfunction

  // A refused word stays on the bus until taken; otherwise draw a fresh one.
  task automatic gen(int i);
    if (!(drv_valid[i] && !m_acc[i])) begin
      drv_valid[i] = ($urandom_range(0, 3) != 0);
      drv_ctrl[i]  = drv_valid[i] ? rand_word() : 32'd0;
    end
  endtask

  task automatic random_phase(int n);
    for (int k = 0; k < n; k++) begin
      gen(0);
      gen(1);
      #1;
      chk_ready(0);
      chk_ready(1);
      advance();
      chk_outs(0);
      chk_outs(1);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] c;
    logic        rdy;
    logic [31:0] ex;
    logic        exv;
    logic [31:0] mem;
    logic [31:0] wb;
    logic [15:0] st;
  } vec_t;

  vec_t tbl [24];

  localparam logic [31:0] ADD = 32'h000221E4;
  localparam logic [31:0] SUB = 32'h00061265;
  localparam logic [31:0] Z   = 32'd0;

  initial begin
    logic [31:0] and_w, mul_w, lw_w, p0_w, r0_w, sw_w, mself_w;
    int          k;

    and_w   = mkw(6, 7, 5, 1'b0, 1'b0, 1'b1);
    mul_w   = mkw(1, 2, 8, 1'b1, 1'b0, 1'b1);
    lw_w    = mkw(1, 3, 9, 1'b0, 1'b1, 1'b1);
    p0_w    = mkw(1, 2, 0, 1'b0, 1'b0, 1'b1);
    r0_w    = mkw(0, 0, 10, 1'b0, 1'b0, 1'b1);
    sw_w    = mkw(1, 3, 0, 1'b0, 1'b1, 1'b0);
    mself_w = mkw(8, 1, 8, 1'b1, 1'b0, 1'b1);

    tbl[0]  = '{1'b1, ADD,   1'b1, ADD,   1'b1, Z,     Z,     16'd0};
    tbl[1]  = '{1'b1, SUB,   1'b0, Z,     1'b0, ADD,   Z,     16'd1};
    tbl[2]  = '{1'b1, SUB,   1'b0, Z,     1'b0, Z,     ADD,   16'd2};
    tbl[3]  = '{1'b1, SUB,   1'b1, SUB,   1'b1, Z,     Z,     16'd2};
    tbl[4]  = '{1'b1, and_w, 1'b1, and_w, 1'b1, SUB,   Z,     16'd2};
    tbl[5]  = '{1'b0, Z,     1'b1, Z,     1'b0, and_w, SUB,   16'd2};
    tbl[6]  = '{1'b1, mul_w, 1'b1, mul_w, 1'b1, Z,     and_w, 16'd2};
    tbl[7]  = '{1'b1, ADD,   1'b0, mul_w, 1'b1, Z,     Z,     16'd3};
    tbl[8]  = '{1'b1, ADD,   1'b0, mul_w, 1'b1, Z,     Z,     16'd4};
    tbl[9]  = '{1'b1, ADD,   1'b1, ADD,   1'b1, mul_w, Z,     16'd4};
    tbl[10] = '{1'b0, Z,     1'b1, Z,     1'b0, ADD,   mul_w, 16'd4};
    tbl[11] = '{1'b0, Z,     1'b1, Z,     1'b0, Z,     ADD,   16'd4};
    tbl[12] = '{1'b1, ADD,   1'b1, ADD,   1'b1, Z,     Z,     16'd4};
    tbl[13] = '{1'b1, lw_w,  1'b1, lw_w,  1'b1, ADD,   Z,     16'd4};
    tbl[14] = '{1'b1, p0_w,  1'b1, p0_w,  1'b1, lw_w,  ADD,   16'd4};
    tbl[15] = '{1'b1, r0_w,  1'b1, r0_w,  1'b1, p0_w,  lw_w,  16'd4};
    tbl[16] = '{1'b1, ADD,   1'b1, ADD,   1'b1, r0_w,  p0_w,  16'd4};
    tbl[17] = '{1'b1, sw_w,  1'b0, Z,     1'b0, ADD,   r0_w,  16'd5};
    tbl[18] = '{1'b1, sw_w,  1'b0, Z,     1'b0, Z,     ADD,   16'd6};
    tbl[19] = '{1'b1, sw_w,  1'b1, sw_w,  1'b1, Z,     Z,     16'd6};
    tbl[20] = '{1'b1, mul_w, 1'b1, mul_w, 1'b1, sw_w,  Z,     16'd6};
    tbl[21] = '{1'b0, Z,     1'b0, mul_w, 1'b1, Z,     sw_w,  16'd6};
    tbl[22] = '{1'b0, Z,     1'b0, mul_w, 1'b1, Z,     Z,     16'd6};
    tbl[23] = '{1'b0, Z,     1'b1, Z,     1'b0, mul_w, Z,     16'd6};

    for (int i = 0; i < 2; i++) begin
      drv_ctrl[i]  = 32'd0;
      drv_valid[i] = 1'b0;
      model_reset(i);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready%0d", i), 32'(obs_ready[i]), 32'd1);
      chk_outs(i);
    end

    // Directed table on instance 0.
    for (int r = 0; r < 24; r++) begin
      drv_valid[0] = tbl[r].v;
      drv_ctrl[0]  = tbl[r].c;
      #1;
      chk($sformatf("row%0d_ready", r), 32'(obs_ready[0]), 32'(tbl[r].rdy));
      advance();
      chk($sformatf("row%0d_ex", r), obs_ex[0], tbl[r].ex);
      chk($sformatf("row%0d_exv", r), 32'(obs_exv[0]), 32'(tbl[r].exv));
      chk($sformatf("row%0d_mem", r), obs_mem[0], tbl[r].mem);
      chk($sformatf("row%0d_memv", r), 32'(obs_memv[0]), 32'(tbl[r].mem != Z));
      chk($sformatf("row%0d_wb", r), obs_wb[0], tbl[r].wb);
      chk($sformatf("row%0d_wbv", r), 32'(obs_wbv[0]), 32'(tbl[r].wb != Z));
      chk($sformatf("row%0d_stall", r), 32'(obs_stall[0]), 32'(tbl[r].st));
    end
    drv_valid[0] = 1'b0;
    drv_ctrl[0]  = 32'd0;

    // RAW hazard with WB included in the checks: three refused cycles.
    drv_valid[1] = 1'b1;
    drv_ctrl[1]  = ADD;
    #1;
    chk("b_add_ready", 32'(obs_ready[1]), 32'd1);
    advance();
    drv_ctrl[1] = SUB;
    k = 0;
    #1;
    while (!obs_ready[1] && k < 10) begin
      advance();
      k++;
      #1;
    end
    chk("b_raw_stalls", 32'(k), 32'd3);
    advance();
    chk("b_sub_ex", obs_ex[1], SUB);
    chk("b_sub_mem", obs_mem[1], Z);
    chk("b_sub_wb", obs_wb[1], Z);
    chk("b_stall", 32'(obs_stall[1]), 32'd3);
    chk_outs(1);
    drv_valid[1] = 1'b0;
    drv_ctrl[1]  = 32'd0;
    m_acc[1]     = 1'b1;

    random_phase(1500);

    // Asynchronous reset of instance 0 between clock edges.
    #2;
    rst_a = 1'b1;
    drv_valid[0] = 1'b0;
    drv_ctrl[0]  = 32'd0;
    model_reset(0);
    #1;
    chk("async_ex", obs_ex[0], Z);
    chk("async_exv", 32'(obs_exv[0]), 32'd0);
    chk("async_mem", obs_mem[0], Z);
    chk("async_wb", obs_wb[0], Z);
    chk("async_stall", 32'(obs_stall[0]), 32'd0);
    chk("async_ready", 32'(obs_ready[0]), 32'd1);
    advance();
    #1;
    rst_a = 1'b0;
    #1;
    chk("post_rst_ready", 32'(obs_ready[0]), 32'd1);
    chk_outs(0);

    random_phase(300);

    // Saturation: back-to-back self-dependent multiplies on instance 1.
    drv_valid[0] = 1'b0;
    drv_ctrl[0]  = 32'd0;
    #1;
    rst_b = 1'b1;
    model_reset(1);
    #1;
    rst_b = 1'b0;
    drv_valid[1] = 1'b1;
    drv_ctrl[1]  = mself_w;
    for (int n = 0; n < 70000; n++) begin
      advance();
      if ((n % 4096) == 0) chk("sat_track", 32'(obs_stall[1]), 32'(m_stall[1]));
    end
    chk("sat_full", 32'(obs_stall[1]), 32'h0000FFFF);
    repeat (200) advance();
    chk("sat_hold", 32'(obs_stall[1]), 32'h0000FFFF);
    chk_outs(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
